bios_fetch_stage: RTL
=====================

BIOS_FETCH_STAGE -- requirements
Module: bios_fetch_stage

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, the BIOS word-address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h4000_0000, the first fetch address.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port bios_addr, output, AWIDTH bits: word address driven to the asynchronous-read BIOS RAM port.
REQ-006 SHALL have port bios_dout, input, 32 bits: read data returned combinationally, in the same cycle, for bios_addr.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-009 SHALL have port inst_valid, output, 1 bit: instruction available to decode.
REQ-010 SHALL have port inst_ready, input, 1 bit: decode accepts the instruction.
REQ-011 SHALL have port inst, output, 32 bits: instruction word.
REQ-012 SHALL have port inst_pc, output, 32 bits: PC of inst.
REQ-013 SHALL have port fetch_fault, output, 1 bit: sticky out-of-range or misaligned fetch flag.

Function
REQ-014 SHALL hold a 32-bit fetch PC; bios_addr = pc[AWIDTH+1:2], combinational from the PC register.
REQ-015 SHALL treat PC as in-range when pc[31:AWIDTH+2] == RESET_PC[31:AWIDTH+2] and pc[1:0] == 2'b00.
REQ-016 SHALL buffer fetched {pc, bios_dout} pairs in a 2-entry FIFO; inst_valid = (count != 0); inst/inst_pc = head entry, and 0 when empty.
REQ-017 SHALL push, and advance pc by 4 (modulo 2^32), in a cycle when: no redirect, fetch_fault = 0, PC in-range, and (count < 2 or a pop occurs that cycle).
REQ-018 SHALL pop when inst_valid && inst_ready; simultaneous push and pop at count = 2 SHALL keep count = 2 with no data loss.
REQ-019 SHALL hold pc and count unchanged when the FIFO is full and there is no pop; bios_addr stays stable.
REQ-020 SHALL, on redirect_valid, at the next edge: clear the FIFO; set pc = redirect_pc; clear fetch_fault; neither push nor pop that cycle (inst_ready is ignored).
REQ-021 SHALL, when a push would otherwise occur but PC is out of range or misaligned, set fetch_fault at the next edge, with no push and pc unchanged.
REQ-022 SHALL, while fetch_fault = 1, stop all pushes; entries already in the FIFO continue to drain normally.
REQ-023 SHALL accept a misaligned redirect_pc without check; the fault is raised on the following fetch attempt per REQ-021.
REQ-024 SHALL give latency: an in-range PC loaded at edge N appears on inst with inst_valid = 1 after edge N+1.

Reset
REQ-025 SHALL, while rst is high at an edge, set pc = RESET_PC, count = 0, and fetch_fault = 0; inst_valid, inst, and inst_pc are therefore 0.
REQ-026 SHALL give rst priority over redirect_valid, push, and pop; a reset mid-stream discards all buffered entries.
REQ-027 SHALL, in the first cycle after reset, present bios_addr = RESET_PC[AWIDTH+1:2].

Structure
REQ-028 SHALL take RESET_PC default, instruction width (32), and FIFO depth (2) from the shared BIOS/CPU constants package.
REQ-029 SHALL place the 2-entry FIFO (count, head/tail pointers, 64-bit entries) in one sub-module, bios_fetch_skid.
REQ-030 SHALL keep all other logic (PC, range check, fault, redirect) in bios_fetch_stage.

Verification
REQ-031 Reset release with inst_ready = 1 and BIOS words 0x00000013 / 0x00100093 at word addresses 0 / 1 -> inst_valid rises one edge after reset; inst_pc = 0x40000000 then 0x40000004, one instruction per cycle.
REQ-032 inst_ready held 0 for 5 cycles -> count saturates at 2; bios_addr frozen at word 2; on release, PCs 0x40000000, 0x40000004, 0x40000008 in order with no gaps or duplicates.
REQ-033 redirect_valid with redirect_pc = 0x40000100 while FIFO is full and inst_ready = 1 -> no pop that cycle; next cycle inst_valid = 0; following cycle inst_pc = 0x40000100.
REQ-034 redirect_pc = 0x10000000 -> next edge fetch_fault = 1, inst_valid stays 0; then redirect to 0x40000008 -> fetch_fault clears and the fetch resumes.
REQ-035 redirect_pc = 0x40000002 -> fetch_fault set one cycle later with no push; last in-range word at 0x40003FFC followed by pc 0x40004000 -> fault, no wrap to word 0.
REQ-036 rst asserted with 2 entries buffered and inst_ready = 1 -> no pop recorded; after the reset edge inst_valid = 0 and bios_addr = 0.

Source files
------------

// File: rtl/bios_fetch_stage_pkg.sv
// Shared BIOS/CPU constants and the fetch-buffer entry payload.
package bios_fetch_stage_pkg;

  localparam int unsigned INST_W        = 32;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned FETCH_DEPTH   = 2;
  localparam int unsigned FETCH_CNT_W   = 2;
  localparam logic [31:0] BIOS_RESET_PC = 32'h4000_0000;

  // One buffered fetch: the PC and the instruction word read at that PC.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage : bios_fetch_stage_pkg

// File: rtl/bios_fetch_stage_if.sv
// Fetch-to-decode valid/ready handshake carrying an instruction and its PC.
interface bios_fetch_stage_if;
  import bios_fetch_stage_pkg::*;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface : bios_fetch_stage_if

// File: rtl/bios_fetch_skid.sv
// Two-entry fetch buffer: count plus head/tail pointers over two entries.
// The head entry is presented combinationally and reads as zero when empty.
module bios_fetch_skid
  import bios_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_entry,
  input  logic                   i_pop,
  output logic [FETCH_CNT_W-1:0] o_count,
  output fetch_entry_t           o_head_c
);

  fetch_entry_t           r_mem [FETCH_DEPTH];
  logic                   r_head;
  logic                   r_tail;
  logic [FETCH_CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  // Qualify requests so the buffer can never underflow or overflow.
  always_comb begin
    w_pop  = i_pop && (r_count != FETCH_CNT_W'(0));
    w_push = i_push && ((r_count < FETCH_CNT_W'(FETCH_DEPTH)) || w_pop);
  end

  // Pointer and occupancy update; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FETCH_CNT_W'(1);
        2'b01:   r_count <= r_count - FETCH_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; a full push+pop overwrites the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_flush) r_mem[r_tail] <= i_entry;
  end

  // Head presentation.
  always_comb begin
    o_head_c = '0;
    if (r_count != FETCH_CNT_W'(0)) o_head_c = r_mem[r_head];
  end

  assign o_count = r_count;

endmodule : bios_fetch_skid

// File: rtl/bios_fetch_stage.sv
// BIOS instruction fetch: PC sequencing, range/alignment check with sticky
// fault, redirect handling, and a two-entry buffer toward decode.
module bios_fetch_stage
  import bios_fetch_stage_pkg::*;
#(
  parameter int unsigned AWIDTH   = 12,
  parameter logic [31:0] RESET_PC = BIOS_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] bios_addr,
  input  logic [INST_W-1:0] bios_dout,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  bios_fetch_stage_if.master dec,
  output logic              fetch_fault
);

  logic [PC_W-1:0]        r_pc;
  logic                   r_fault;

  logic [FETCH_CNT_W-1:0] w_count;
  fetch_entry_t           w_head;
  fetch_entry_t           w_entry;
  logic                   w_in_range;
  logic                   w_pop;
  logic                   w_attempt;
  logic                   w_push;
  logic                   w_flush;

  // Fetch control: a fetch is attempted when not redirecting, not faulted and
  // the buffer has (or is making) room; it pushes only for a legal PC.
  always_comb begin
    w_in_range = (r_pc[31:AWIDTH+2] == RESET_PC[31:AWIDTH+2]) &&
                 (r_pc[1:0] == 2'b00);
    w_pop      = dec.inst_valid && dec.inst_ready && !redirect_valid;
    w_attempt  = !redirect_valid && !r_fault &&
                 ((w_count < FETCH_CNT_W'(FETCH_DEPTH)) || w_pop);
    w_push     = w_attempt && w_in_range;
    w_flush    = redirect_valid;
    w_entry    = '{pc: r_pc, inst: bios_dout};
  end

  // PC and sticky fault state; reset dominates redirect, which dominates fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_fault <= 1'b0;
    end else if (w_push) begin
      r_pc    <= r_pc + PC_W'(4);
    end else if (w_attempt) begin
      r_fault <= 1'b1;
    end
  end

  bios_fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (w_flush),
    .i_push   (w_push),
    .i_entry  (w_entry),
    .i_pop    (w_pop),
    .o_count  (w_count),
    .o_head_c (w_head)
  );

  // Output drive toward BIOS RAM and decode.
  always_comb begin
    bios_addr      = r_pc[AWIDTH+1:2];
    dec.inst_valid = (w_count != FETCH_CNT_W'(0));
    dec.inst       = w_head.inst;
    dec.inst_pc    = w_head.pc;
    fetch_fault    = r_fault;
  end

endmodule : bios_fetch_stage
